// File: rtl/ddr4_pkg.sv
// ddr4_pkg: shared types and command encodings for the DDR4 command sequencer
// Provides the sequencer FSM state enum, the command enum, the
// {act_n, A16, A15, A14} encoding of each command and the address bit
// positions that carry command information.
package ddr4_pkg;
    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_PRE_WAIT, S_ACT, S_ACT_WAIT, S_CAS,
        S_REF_PREA, S_REF_PRE_WAIT, S_REF, S_REF_WAIT
    } state_t;

    typedef enum logic [2:0] {
        CMD_DES, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_PREA, CMD_REF
    } cmd_t;

    localparam int A10 = 10;
    localparam int A14 = 14;
    localparam int A16 = 16;

    localparam logic [3:0] ENC_DES = 4'b1111;
    localparam logic [3:0] ENC_ACT = 4'b0000;
    localparam logic [3:0] ENC_RD  = 4'b1101;
    localparam logic [3:0] ENC_WR  = 4'b1100;
    localparam logic [3:0] ENC_PRE = 4'b1010;
    localparam logic [3:0] ENC_REF = 4'b1001;

    // {act_n, A16, A15, A14}; PRE and PREA differ only in A10
    function automatic logic [3:0] cmd_enc(input cmd_t c);
        return c == CMD_DES ? ENC_DES :
               c == CMD_ACT ? ENC_ACT :
               c == CMD_RD  ? ENC_RD  :
               c == CMD_WR  ? ENC_WR  :
               c == CMD_REF ? ENC_REF : ENC_PRE;
    endfunction
endpackage

// File: rtl/ddr_timer.sv
// ddr_timer: loadable down-counter that saturates at zero
// Ports: i_clk clock, i_rst sync active-high reset (count -> 0),
//        i_load loads i_value, o_expired high while the count is zero.
module ddr_timer #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_expired
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_count <= '0;
        else if (i_load)
            r_count <= i_value;
        else if (r_count != '0)
            r_count <= r_count - WIDTH'(1);
    end

    assign o_expired = r_count == '0;
endmodule

// File: rtl/dimm_cmd_sequencer.sv
// dimm_cmd_sequencer: DDR4 command-pin driver with open-row tracking and refresh
// Ports: ck_t clock, reset sync active-high reset;
//        req_valid/req_ready handshake with req_write, req_bg, req_ba, req_row, req_col;
//        cke, cs_n, act_n, addr, bg, ba registered DDR4 command bus;
//        cas_issued pulses with each RD/WR, refresh_busy high during the refresh sequence.
module dimm_cmd_sequencer
    import ddr4_pkg::*;
#(
    parameter int ADDRWIDTH     = 17,
    parameter int BANKGROUPS    = 4,
    parameter int BANKSPERGROUP = 4,
    parameter int COLS          = 1024,
    parameter int T_RCD         = 14,
    parameter int T_RP          = 14,
    parameter int T_RAS         = 32,
    parameter int T_CCD         = 4,
    parameter int T_RFC         = 260,
    parameter int T_REFI        = 6240,
    localparam int BGWIDTH      = $clog2(BANKGROUPS),
    localparam int BAWIDTH      = $clog2(BANKSPERGROUP),
    localparam int COLWIDTH     = $clog2(COLS)
) (
    input  logic                 ck_t,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [BGWIDTH-1:0]   req_bg,
    input  logic [BAWIDTH-1:0]   req_ba,
    input  logic [ADDRWIDTH-1:0] req_row,
    input  logic [COLWIDTH-1:0]  req_col,
    output logic                 cke,
    output logic                 cs_n,
    output logic                 act_n,
    output logic [ADDRWIDTH-1:0] addr,
    output logic [BGWIDTH-1:0]   bg,
    output logic [BAWIDTH-1:0]   ba,
    output logic                 cas_issued,
    output logic                 refresh_busy
);
    localparam int NB = BANKGROUPS * BANKSPERGROUP;
    localparam int IW = BGWIDTH + BAWIDTH;
    // the sum bounds every individual load value
    localparam int TW = $clog2(T_REFI + T_RFC + T_RAS + T_RP + T_RCD + T_CCD);

    state_t                 r_state, w_next;
    cmd_t                   w_cmd;
    logic                   r_pending;
    logic [NB-1:0]          r_open;
    logic [ADDRWIDTH-1:0]   r_bank_row [NB];
    logic                   r_write;
    logic [BGWIDTH-1:0]     r_bg;
    logic [BAWIDTH-1:0]     r_ba;
    logic [ADDRWIDTH-1:0]   r_row;
    logic [COLWIDTH-1:0]    r_col;
    logic [IW-1:0]          w_req_idx, w_idx;
    logic                   w_accept, w_hit, w_wait_ld;
    logic                   w_wait_exp, w_act_exp, w_ccd_exp, w_refi_exp;
    logic [TW-1:0]          w_wait_val;
    logic [3:0]             w_enc;
    logic [ADDRWIDTH-1:0]   w_addr;

    assign w_req_idx    = {req_bg, req_ba};
    assign w_idx        = {r_bg, r_ba};
    assign w_hit        = r_open[w_req_idx] && r_bank_row[w_req_idx] == req_row;
    assign req_ready    = r_state == S_IDLE && !r_pending && cke;
    assign w_accept     = req_valid && req_ready;
    assign refresh_busy = r_state inside {S_REF_PREA, S_REF_PRE_WAIT, S_REF, S_REF_WAIT};
    assign w_enc        = cmd_enc(w_cmd);

    ddr_timer #(.WIDTH(TW)) u_wait (
        .i_clk(ck_t), .i_rst(reset), .i_load(w_wait_ld),
        .i_value(w_wait_val), .o_expired(w_wait_exp)
    );
    ddr_timer #(.WIDTH(TW)) u_act (
        .i_clk(ck_t), .i_rst(reset), .i_load(w_cmd == CMD_ACT),
        .i_value(TW'(T_RAS - 1)), .o_expired(w_act_exp)
    );
    ddr_timer #(.WIDTH(TW)) u_ccd (
        .i_clk(ck_t), .i_rst(reset), .i_load(w_cmd == CMD_RD || w_cmd == CMD_WR),
        .i_value(TW'(T_CCD - 1)), .o_expired(w_ccd_exp)
    );
    // starts at zero, so the first refresh follows reset immediately
    ddr_timer #(.WIDTH(TW)) u_refi (
        .i_clk(ck_t), .i_rst(reset), .i_load(w_refi_exp),
        .i_value(TW'(T_REFI - 1)), .o_expired(w_refi_exp)
    );

    // the wait states issue the follow-on command in the cycle the timer
    // reaches zero, keeping PRE->ACT, ACT->CAS and PREA->REF exact
    always_comb begin
        w_next     = r_state;
        w_cmd      = CMD_DES;
        w_wait_ld  = 1'b0;
        w_wait_val = '0;
        case (r_state)
            S_IDLE:
                if (r_pending)
                    w_next = S_REF_PREA;
                else if (w_accept)
                    w_next = w_hit ? S_CAS : r_open[w_req_idx] ? S_PRE : S_ACT;
            S_PRE:
                if (w_act_exp) begin
                    w_cmd      = CMD_PRE;
                    w_wait_ld  = 1'b1;
                    w_wait_val = TW'(T_RP - 1);
                    w_next     = S_PRE_WAIT;
                end
            S_PRE_WAIT, S_ACT:
                if (r_state == S_ACT || w_wait_exp) begin
                    w_cmd      = CMD_ACT;
                    w_wait_ld  = 1'b1;
                    w_wait_val = TW'(T_RCD - 1);
                    w_next     = S_ACT_WAIT;
                end
            S_ACT_WAIT, S_CAS:
                if (r_state == S_CAS || w_wait_exp) begin
                    w_cmd  = !w_ccd_exp ? CMD_DES : r_write ? CMD_WR : CMD_RD;
                    w_next = w_ccd_exp ? S_IDLE : S_CAS;
                end
            S_REF_PREA:
                if (r_open == '0)
                    w_next = S_REF;
                else if (w_act_exp) begin
                    w_cmd      = CMD_PREA;
                    w_wait_ld  = 1'b1;
                    w_wait_val = TW'(T_RP - 1);
                    w_next     = S_REF_PRE_WAIT;
                end
            S_REF_PRE_WAIT, S_REF:
                if (r_state == S_REF || w_wait_exp) begin
                    w_cmd      = CMD_REF;
                    w_wait_ld  = 1'b1;
                    w_wait_val = TW'(T_RFC - 1);
                    w_next     = S_REF_WAIT;
                end
            S_REF_WAIT:
                if (w_wait_exp)
                    w_next = S_IDLE;
            default:
                w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_addr          = '0;
        w_addr[A16:A14] = w_enc[2:0];
        if (w_cmd == CMD_RD || w_cmd == CMD_WR)
            w_addr[COLWIDTH-1:0] = r_col;
        w_addr[A10]     = w_cmd == CMD_PREA;
        if (w_cmd == CMD_ACT)
            w_addr = r_row;
    end

    always_ff @(posedge ck_t) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pending  <= 1'b0;
            r_open     <= '0;
            cke        <= 1'b0;
            cs_n       <= 1'b1;
            act_n      <= 1'b1;
            addr       <= '0;
            bg         <= '0;
            ba         <= '0;
            cas_issued <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_pending  <= w_refi_exp || (r_pending && w_cmd != CMD_REF);
            cke        <= 1'b1;
            cs_n       <= w_cmd == CMD_DES;
            act_n      <= w_enc[3];
            cas_issued <= w_cmd == CMD_RD || w_cmd == CMD_WR;
            if (w_cmd != CMD_DES)
                addr <= w_addr;
            if (w_cmd inside {CMD_ACT, CMD_RD, CMD_WR, CMD_PRE}) begin
                bg <= r_bg;
                ba <= r_ba;
            end
            if (w_cmd == CMD_ACT)
                r_open[w_idx] <= 1'b1;
            if (w_cmd == CMD_PRE)
                r_open[w_idx] <= 1'b0;
            if (w_cmd == CMD_PREA)
                r_open <= '0;
        end
    end

    // row tags and the latched request are only meaningful behind r_open / the FSM
    always_ff @(posedge ck_t) begin
        if (w_cmd == CMD_ACT)
            r_bank_row[w_idx] <= r_row;
        if (w_accept) begin
            r_write <= req_write;
            r_bg    <= req_bg;
            r_ba    <= req_ba;
            r_row   <= req_row;
            r_col   <= req_col;
        end
    end
endmodule
